// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VDG display fetches take priority over CPU req/ack accesses.
// Optional sticky fetch-overwrite flag (vdg_ovf/ovf_clr) is enabled by defining VRAM_OVF_EN.
module vram_arbiter #(
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned RAM_LAT = 1
) (
   input  logic              clk_10,
   input  logic              reset,
   input  logic              vdg_req,
   input  logic [ADDR_W-1:0] vdg_addr,
   output logic [7:0]        vdg_data,
   output logic              vdg_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata
`ifdef VRAM_OVF_EN
   ,
   input  logic              ovf_clr,
   output logic              vdg_ovf
`endif
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   localparam logic [1:0] Lat = RAM_LAT[1:0];

   state_t            r_state, w_state;
   logic              r_vdg_pend, w_vdg_pend;
   logic [ADDR_W-1:0] r_vdg_addr, w_vdg_addr;
   logic              r_owner_vdg, w_owner_vdg;
   logic              r_cpu_wr, w_cpu_wr;
   logic [1:0]        r_cnt, w_cnt;
   logic [7:0]        r_cap, w_cap;
   logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
   logic [7:0]        r_ram_wdata, w_ram_wdata;
   logic              r_ram_we, w_ram_we;
   logic [7:0]        r_vdg_data, w_vdg_data;
   logic              r_vdg_valid, w_vdg_valid;
   logic [7:0]        r_cpu_rdata, w_cpu_rdata;
   logic              r_cpu_ack, w_cpu_ack;

   always_comb begin
      w_state     = r_state;
      w_vdg_pend  = r_vdg_pend;
      w_vdg_addr  = r_vdg_addr;
      w_owner_vdg = r_owner_vdg;
      w_cpu_wr    = r_cpu_wr;
      w_cnt       = r_cnt;
      w_cap       = r_cap;
      w_ram_addr  = r_ram_addr;
      w_ram_wdata = r_ram_wdata;
      w_ram_we    = 1'b0;
      w_vdg_data  = r_vdg_data;
      w_vdg_valid = 1'b0;
      w_cpu_rdata = r_cpu_rdata;
      w_cpu_ack   = 1'b0;

      case (r_state)
         StIdle: begin
            if (r_vdg_pend) begin
               w_ram_addr  = r_vdg_addr;
               w_owner_vdg = 1'b1;
               w_vdg_pend  = 1'b0;
               w_cnt       = 2'd0;
               w_state     = StBusy;
            end else if (cpu_req) begin
               w_ram_addr  = cpu_addr;
               w_ram_wdata = cpu_wdata;
               w_ram_we    = cpu_we;
               w_cpu_wr    = cpu_we;
               w_owner_vdg = 1'b0;
               w_cnt       = 2'd0;
               w_state     = StBusy;
            end
         end
         StBusy: begin
            if (r_cnt == Lat) begin
               w_cap   = ram_rdata;
               w_cnt   = 2'd0;
               w_state = StDone;
            end else begin
               w_cnt = r_cnt + 2'd1;
            end
         end
         StDone: begin
            if (r_owner_vdg) begin
               w_vdg_data  = r_cap;
               w_vdg_valid = 1'b1;
            end else begin
               w_cpu_ack = 1'b1;
               if (!r_cpu_wr) w_cpu_rdata = r_cap;
            end
            w_state = StIdle;
         end
         default: w_state = StIdle;
      endcase

      // A request on the grant edge re-arms the pending flag after the grant cleared it.
      if (vdg_req) begin
         w_vdg_pend = 1'b1;
         w_vdg_addr = vdg_addr;
      end
   end

   always_ff @(posedge clk_10 or posedge reset) begin
      if (reset) begin
         r_state     <= StIdle;
         r_vdg_pend  <= 1'b0;
         r_vdg_addr  <= '0;
         r_owner_vdg <= 1'b0;
         r_cpu_wr    <= 1'b0;
         r_cnt       <= 2'd0;
         r_cap       <= 8'h00;
         r_ram_addr  <= '0;
         r_ram_wdata <= 8'h00;
         r_ram_we    <= 1'b0;
         r_vdg_data  <= 8'h00;
         r_vdg_valid <= 1'b0;
         r_cpu_rdata <= 8'h00;
         r_cpu_ack   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_vdg_pend  <= w_vdg_pend;
         r_vdg_addr  <= w_vdg_addr;
         r_owner_vdg <= w_owner_vdg;
         r_cpu_wr    <= w_cpu_wr;
         r_cnt       <= w_cnt;
         r_cap       <= w_cap;
         r_ram_addr  <= w_ram_addr;
         r_ram_wdata <= w_ram_wdata;
         r_ram_we    <= w_ram_we;
         r_vdg_data  <= w_vdg_data;
         r_vdg_valid <= w_vdg_valid;
         r_cpu_rdata <= w_cpu_rdata;
         r_cpu_ack   <= w_cpu_ack;
      end
   end

   assign vdg_data  = r_vdg_data;
   assign vdg_valid = r_vdg_valid;
   assign cpu_rdata = r_cpu_rdata;
   assign cpu_ack   = r_cpu_ack;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign ram_we    = r_ram_we;

`ifdef VRAM_OVF_EN
   logic r_ovf, w_ovf;

   always_comb begin
      w_ovf = r_ovf;
      if (ovf_clr) w_ovf = 1'b0;
      if (vdg_req && (r_vdg_pend || (r_owner_vdg && (r_state != StIdle)))) w_ovf = 1'b1;
   end

   always_ff @(posedge clk_10 or posedge reset) begin
      if (reset) r_ovf <= 1'b0;
      else       r_ovf <= w_ovf;
   end

   assign vdg_ovf = r_ovf;
`endif

endmodule
